// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding and the abort data word
// returned when a memory access times out.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Watchdog for a single memory transaction: counts cycles while the arbiter is
// busy and flags the last allowed cycle so the access can be aborted.
module timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Restart from zero every time the arbiter leaves BUSY, so each access gets a full budget.
  always_comb begin
    cnt_d = active_i ? cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = active_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single unified memory.
// Data wins by default; a starvation counter guarantees instruction fetch progress.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic [31:0] irdata,
  output logic        iready,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          gnt_data_q, gnt_data_d;
  logic [31:0]   irdata_q, irdata_d;
  logic [31:0]   drdata_q, drdata_d;
  logic          err_q, err_d;

  logic busy;
  logic expired;
  logic starve_full;

  assign busy        = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign starve_full = (starve_q == SW'(STARVE_LIMIT));

  timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .active_i (busy),
    .expired_o(expired)
  );

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    state_d    = state_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    gnt_data_d = gnt_data_q;
    irdata_d   = irdata_q;
    drdata_d   = drdata_q;
    err_d      = err_q;

    unique case (state_q)
      ST_IDLE: begin
        // A waiting data request still wins at the limit when no fetch is pending.
        if (dreq && (!starve_full || !ireq)) begin
          state_d    = ST_BUSY_D;
          addr_d     = daddr;
          wdata_d    = dwdata;
          we_d       = dwe;
          gnt_data_d = 1'b1;
          if (ireq && !starve_full) starve_d = starve_q + SW'(1);
        end else if (ireq) begin
          state_d    = ST_BUSY_I;
          addr_d     = iaddr;
          wdata_d    = '0;
          we_d       = 1'b0;
          gnt_data_d = 1'b0;
          starve_d   = '0;
        end
      end
      ST_BUSY_I: begin
        if (mem_ack) begin
          irdata_d = mem_rdata;
          state_d  = ST_RESP;
        end else if (expired) begin
          irdata_d = ABORT_DATA;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_BUSY_D: begin
        if (mem_ack) begin
          drdata_d = we_q ? 32'h0 : mem_rdata;
          state_d  = ST_RESP;
        end else if (expired) begin
          drdata_d = ABORT_DATA;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only real state is reset; the combinational outputs fall out of state_q = IDLE.
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      gnt_data_q <= 1'b0;
      irdata_q   <= '0;
      drdata_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      gnt_data_q <= gnt_data_d;
      irdata_q   <= irdata_d;
      drdata_q   <= drdata_d;
      err_q      <= err_d;
    end
  end

  assign mem_req   = busy;
  assign mem_we    = (state_q == ST_BUSY_D) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign iready    = (state_q == ST_RESP) && !gnt_data_q;
  assign dready    = (state_q == ST_RESP) &&  gnt_data_q;
  assign irdata    = irdata_q;
  assign drdata    = drdata_q;
  assign err       = err_q;
  assign stall_if  = ireq & ~iready;
  assign stall_mem = dreq & ~dready;

endmodule
